// File: rtl/pc_unit.sv
// Program counter unit: next-PC selection, held redirects while the fetch is
// not advancing, exception entry/return with saved EPC, and a terminal halt.
module pc_unit #(
    parameter int          PC_W     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            stall,
    input  logic [2:0]      pcsrc,
    input  logic            branch_taken,
    input  logic [15:0]     boffset,
    input  logic [25:0]     jaddr,
    input  logic [PC_W-1:0] rdat,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic [PC_W-1:0] epc,
    output logic            redir_pending,
    output logic            halted,
    output logic            misalign
);

    localparam logic [2:0] SRC_ADD4   = 3'd0;
    localparam logic [2:0] SRC_JUMP   = 3'd1;
    localparam logic [2:0] SRC_JR     = 3'd2;
    localparam logic [2:0] SRC_BRANCH = 3'd3;
    localparam logic [2:0] SRC_EXC    = 3'd4;
    localparam logic [2:0] SRC_ERET   = 3'd5;

    localparam logic [PC_W-1:0] RST_V = RESET_PC[PC_W-1:0];
    localparam logic [PC_W-1:0] EXC_V = EXC_VEC[PC_W-1:0];

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [PC_W-1:0] r_epc, w_epc_next;
    logic [PC_W-1:0] r_held, w_held_next;
    logic            r_held_eret, w_held_eret_next;
    logic            r_misalign, w_misalign_next;

    logic            w_adv;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_boff_ext;
    logic [PC_W-1:0] w_target;
    logic            w_redirect;
    logic            w_jr_misalign;

    assign w_adv         = ihit && !stall;
    assign w_pc_plus4    = r_pc + PC_W'(4);
    assign w_boff_ext    = {{(PC_W-18){boffset[15]}}, boffset, 2'b00};
    assign w_jr_misalign = (pcsrc == SRC_JR) && (rdat[1:0] != 2'b00);
    // Sources that leave the sequential path; a not-taken branch is just ADD4.
    assign w_redirect    = (pcsrc == SRC_JUMP) || (pcsrc == SRC_JR) || (pcsrc == SRC_ERET) ||
                           ((pcsrc == SRC_BRANCH) && branch_taken);

    always_comb begin
        w_target = w_pc_plus4;
        case (pcsrc)
            SRC_JUMP:   w_target = {w_pc_plus4[PC_W-1:28], jaddr, 2'b00};
            SRC_JR:     w_target = {rdat[PC_W-1:2], 2'b00};
            SRC_BRANCH: if (branch_taken) w_target = w_pc_plus4 + w_boff_ext;
            SRC_EXC:    w_target = EXC_V;
            SRC_ERET:   w_target = r_epc;
            default:    w_target = w_pc_plus4;
        endcase
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_epc_next       = r_epc;
        w_held_next      = r_held;
        w_held_eret_next = r_held_eret;
        w_misalign_next  = r_misalign;
        case (r_state)
            S_RUN, S_HOLD: begin
                if (halt) begin
                    w_state_next = S_HALTED;
                end else if (pcsrc == SRC_EXC) begin
                    // Exception entry ignores adv and drops any held redirect.
                    w_epc_next       = r_pc;
                    w_pc_next        = EXC_V;
                    w_held_next      = '0;
                    w_held_eret_next = 1'b0;
                    w_state_next     = S_RUN;
                end else if (r_state == S_HOLD) begin
                    if (w_adv) begin
                        w_pc_next        = r_held_eret ? r_epc : r_held;
                        w_held_next      = '0;
                        w_held_eret_next = 1'b0;
                        w_state_next     = S_RUN;
                    end
                end else if (w_adv) begin
                    w_pc_next = w_target;
                    if (w_jr_misalign) w_misalign_next = 1'b1;
                end else if (w_redirect) begin
                    w_held_next      = w_target;
                    w_held_eret_next = (pcsrc == SRC_ERET);
                    w_state_next     = S_HOLD;
                    if (w_jr_misalign) w_misalign_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_RUN;
            r_pc        <= RST_V;
            r_epc       <= '0;
            r_held      <= '0;
            r_held_eret <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_epc       <= w_epc_next;
            r_held      <= w_held_next;
            r_held_eret <= w_held_eret_next;
            r_misalign  <= w_misalign_next;
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign epc           = r_epc;
    assign redir_pending = (r_state == S_HOLD);
    assign halted        = (r_state == S_HALTED);
    assign misalign      = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios followed by randomized traffic, all
// checked against an arithmetic reference model of the PC behaviour.
module tb_pc_unit;

    localparam int PC_W = 32;
    localparam longint MASK = 64'hFFFF_FFFF;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            ihit = 1'b0;
    logic            stall = 1'b0;
    logic [2:0]      pcsrc = 3'd0;
    logic            branch_taken = 1'b0;
    logic [15:0]     boffset = 16'd0;
    logic [25:0]     jaddr = 26'd0;
    logic [PC_W-1:0] rdat = '0;
    logic            halt = 1'b0;
    logic [PC_W-1:0] pc, pc_plus4, epc;
    logic            redir_pending, halted, misalign;

    pc_unit #(.PC_W(PC_W), .RESET_PC(32'h0), .EXC_VEC(32'h80)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .pcsrc(pcsrc),
        .branch_taken(branch_taken), .boffset(boffset), .jaddr(jaddr), .rdat(rdat),
        .halt(halt), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
        .redir_pending(redir_pending), .halted(halted), .misalign(misalign)
    );

    // clock
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: 0 = running, 1 = holding a redirect, 2 = halted
    longint m_pc, m_epc, m_held;
    int     m_mode;
    bit     m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_epc = 0; m_held = 0; m_mode = 0; m_mis = 0;
    endtask

    function automatic longint model_target(input longint cur_pc);
        longint p4;
        longint off;
        p4 = (cur_pc + 4) & MASK;
        off = longint'($signed(boffset));
        case (pcsrc)
            3'd1: return (p4 & 64'hF000_0000) + (longint'(jaddr) * 4);
            3'd2: return longint'(rdat) & 64'hFFFF_FFFC;
            3'd3: return branch_taken ? ((p4 + off * 4) & MASK) : p4;
            3'd4: return 64'h80;
            3'd5: return m_epc;
            default: return p4;
        endcase
    endfunction

    task automatic model_edge();
        bit adv, is_redirect, jr_bad;
        longint t;
        adv = ihit && !stall;
        is_redirect = (pcsrc == 3'd1) || (pcsrc == 3'd2) || (pcsrc == 3'd5) ||
                      (pcsrc == 3'd3 && branch_taken);
        jr_bad = (pcsrc == 3'd2) && (rdat[1:0] != 2'b00);
        t = model_target(m_pc);
        if (m_mode == 2) return;
        if (halt) begin
            m_mode = 2;
        end else if (pcsrc == 3'd4) begin
            m_epc = m_pc; m_pc = 64'h80; m_held = 0; m_mode = 0;
        end else if (m_mode == 1) begin
            if (adv) begin m_pc = m_held; m_mode = 0; end
        end else if (adv) begin
            m_pc = t;
            if (jr_bad) m_mis = 1;
        end else if (is_redirect) begin
            m_held = t; m_mode = 1;
            if (jr_bad) m_mis = 1;
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".pc"}, pc, 32'(m_pc));
        check({where, ".pc_plus4"}, pc_plus4, 32'((m_pc + 4) & MASK));
        check({where, ".epc"}, epc, 32'(m_epc));
        check({where, ".redir"}, 32'(redir_pending), 32'(m_mode == 1));
        check({where, ".halted"}, 32'(halted), 32'(m_mode == 2));
        check({where, ".misalign"}, 32'(misalign), 32'(m_mis));
    endtask

    task automatic drive(input bit i_hit, input bit i_stall, input logic [2:0] src,
                         input bit taken, input logic [15:0] off, input logic [25:0] ja,
                         input logic [31:0] rd, input bit hlt);
        ihit = i_hit; stall = i_stall; pcsrc = src; branch_taken = taken;
        boffset = off; jaddr = ja; rdat = rd; halt = hlt;
    endtask

    // one clock edge: model follows the DUT, outputs compared 1 time unit later
    task automatic step(input string where);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(where);
    endtask

    // asynchronous reset asserted away from any clock edge
    task automatic do_reset();
        nRST = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        @(negedge CLK);
        do_reset();

        // sequential fetch from reset
        check("seq.pc0", pc, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 0);
            step("seq");
            check("seq.pcN", pc, 32'(i * 4));
        end

        // branch taken backwards by one word, then not taken
        drive(1, 0, 3'd2, 0, 16'h0, 26'h0, 32'h100, 0); step("br.setup");
        drive(1, 0, 3'd3, 1, 16'hFFFF, 26'h0, 32'h0, 0); step("br.taken");
        check("br.taken.pc", pc, 32'h100);
        drive(1, 0, 3'd3, 0, 16'hFFFF, 26'h0, 32'h0, 0); step("br.nt");
        check("br.nt.pc", pc, 32'h104);

        // jump held while fetch stalls, later JR requests ignored
        drive(1, 0, 3'd2, 0, 16'h0, 26'h0, 32'h200, 0); step("hold.setup");
        drive(0, 0, 3'd1, 0, 16'h0, 26'h40, 32'h0, 0); step("hold.cap");
        check("hold.cap.redir", 32'(redir_pending), 32'h1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 3'd2, 0, 16'h0, 26'h0, 32'h500, 0); step("hold.wait");
            check("hold.wait.pc", pc, 32'h200);
        end
        drive(1, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 0); step("hold.commit");
        check("hold.commit.pc", pc, 32'h100);
        check("hold.commit.redir", 32'(redir_pending), 32'h0);

        // exception during stall, then return
        drive(1, 0, 3'd2, 0, 16'h0, 26'h0, 32'h300, 0); step("exc.setup");
        drive(1, 1, 3'd4, 0, 16'h0, 26'h0, 32'h0, 0); step("exc.take");
        check("exc.pc", pc, 32'h80);
        check("exc.epc", epc, 32'h300);
        drive(1, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 0); step("exc.seq");
        drive(1, 0, 3'd5, 0, 16'h0, 26'h0, 32'h0, 0); step("eret");
        check("eret.pc", pc, 32'h300);

        // exception discards a held redirect
        drive(0, 0, 3'd1, 0, 16'h0, 26'h123, 32'h0, 0); step("excdrop.cap");
        drive(0, 0, 3'd4, 0, 16'h0, 26'h0, 32'h0, 0); step("excdrop.exc");
        check("excdrop.redir", 32'(redir_pending), 32'h0);
        drive(1, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 0); step("excdrop.adv");
        check("excdrop.pc", pc, 32'h84);

        // misaligned JR target: sticky until reset
        drive(1, 0, 3'd2, 0, 16'h0, 26'h0, 32'h1003, 0); step("mis.jr");
        check("mis.pc", pc, 32'h1000);
        check("mis.flag", 32'(misalign), 32'h1);
        drive(1, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 0); step("mis.keep");
        check("mis.keep", 32'(misalign), 32'h1);

        // reset while holding drops the held redirect
        drive(0, 0, 3'd1, 0, 16'h0, 26'h3FF, 32'h0, 0); step("rsthold.cap");
        do_reset();
        check("rsthold.mis", 32'(misalign), 32'h0);
        drive(1, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0, 0); step("rsthold.adv");
        check("rsthold.pc", pc, 32'h4);

        // halt beats exception, then everything is ignored until reset
        drive(1, 0, 3'd2, 0, 16'h0, 26'h0, 32'h40, 0); step("halt.setup");
        drive(1, 0, 3'd4, 0, 16'h0, 26'h0, 32'h0, 1); step("halt.take");
        check("halt.flag", 32'(halted), 32'h1);
        check("halt.pc", pc, 32'h40);
        check("halt.epc", epc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'($urandom_range(0, 7)), 1, 16'h7, 26'h9, 32'h1003, 0);
            step("halt.ignore");
        end
        check("halt.frozen", pc, 32'h40);
        #2;
        nRST = 1'b0;
        #1;
        check("halt.async.pc", pc, 32'h0);
        check("halt.async.halted", 32'(halted), 32'h0);
        @(negedge CLK);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] src;
            src = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            if (src == 3'd4 && $urandom_range(0, 1) == 0) src = 3'd5;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, src,
                  $urandom_range(0, 1) == 1, 16'($urandom), 26'($urandom), $urandom,
                  $urandom_range(0, 199) == 0);
            step("rand");
            if ($urandom_range(0, 119) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
